// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Desc     : Opcodes, step encodings, control-word layout and instruction
//            lengths shared by the CPU control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } step_t;

    localparam int CW_W          = 15;
    localparam int CW_PC_INC     = 0;
    localparam int CW_PC_OE      = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_MEM_OE     = 4;
    localparam int CW_MEM_LOAD   = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OE      = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OE       = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OE     = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;

    // Number of steps (T0 included) an opcode occupies before returning to T0.
    function automatic logic [2:0] instr_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: instr_len = 3'd4;
            OP_ADD, OP_SUB: instr_len = 3'd5;
            default:        instr_len = 3'd3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_seq_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : step_counter
// Desc     : Fetch/execute step register with run hold, variable-length
//            return to T0 and a sticky HALT state.
// Revision : 1.0 - initial release
// ============================================================================
module step_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [STEP_W-1:0]   step
);

    step_t      r_state;
    step_t      w_state_nxt;
    logic [2:0] w_last;

    assign w_last = instr_len(opcode) - 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_T0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A step at or beyond the last one wraps, so a glitching opcode can never
    // walk the counter into the HALT encoding.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != ST_HALT && run) begin
            if (r_state == ST_T2 && opcode == OP_HLT) begin
                w_state_nxt = ST_HALT;
            end else if (3'(r_state) >= w_last) begin
                w_state_nxt = ST_T0;
            end else begin
                w_state_nxt = step_t'(3'(r_state) + 3'd1);
            end
        end
    end

    assign step = r_state;

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq
// Desc     : Control sequencer for the 8-bit bus CPU; decodes step, opcode
//            and flags into every load / output-enable strobe.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic                pc_inc,
    output logic                pc_oe,
    output logic                pc_load,
    output logic                mar_load,
    output logic                mem_oe,
    output logic                mem_load,
    output logic                ir_load,
    output logic                ir_oe,
    output logic                a_load,
    output logic                a_oe,
    output logic                b_load,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                flags_load,
    output logic                out_load,
    output logic                halted,
    output logic [STEP_W-1:0]   step
);

    logic [STEP_W-1:0] w_step;
    step_t             w_state;
    logic [CW_W-1:0]   w_cw;
    logic              w_en;

    step_counter #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_step_counter (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .opcode (opcode),
        .step   (w_step)
    );

    assign w_state = step_t'(w_step[2:0]);

    always_comb begin
        w_cw = '0;
        case (w_state)
            ST_T0: begin
                w_cw[CW_PC_OE]    = 1'b1;
                w_cw[CW_MAR_LOAD] = 1'b1;
            end
            ST_T1: begin
                w_cw[CW_MEM_OE]  = 1'b1;
                w_cw[CW_IR_LOAD] = 1'b1;
                w_cw[CW_PC_INC]  = 1'b1;
            end
            ST_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        w_cw[CW_IR_OE]    = 1'b1;
                        w_cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        w_cw[CW_IR_OE]  = 1'b1;
                        w_cw[CW_A_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        w_cw[CW_IR_OE]   = 1'b1;
                        w_cw[CW_PC_LOAD] = 1'b1;
                    end
                    OP_JC: begin
                        w_cw[CW_IR_OE]   = flag_c;
                        w_cw[CW_PC_LOAD] = flag_c;
                    end
                    OP_JZ: begin
                        w_cw[CW_IR_OE]   = flag_z;
                        w_cw[CW_PC_LOAD] = flag_z;
                    end
                    OP_OUT: begin
                        w_cw[CW_A_OE]     = 1'b1;
                        w_cw[CW_OUT_LOAD] = 1'b1;
                    end
                    OP_NOP, OP_HLT: begin
                    end
                    default: begin
                    end
                endcase
            end
            ST_T3: begin
                case (opcode)
                    OP_LDA: begin
                        w_cw[CW_MEM_OE] = 1'b1;
                        w_cw[CW_A_LOAD] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_cw[CW_MEM_OE] = 1'b1;
                        w_cw[CW_B_LOAD] = 1'b1;
                    end
                    OP_STA: begin
                        w_cw[CW_A_OE]     = 1'b1;
                        w_cw[CW_MEM_LOAD] = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    w_cw[CW_ALU_OE]     = 1'b1;
                    w_cw[CW_A_LOAD]     = 1'b1;
                    w_cw[CW_FLAGS_LOAD] = 1'b1;
                    w_cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                end
            end
            default: begin
            end
        endcase
    end

    // Reset and a stalled run both suppress every strobe so nothing loads.
    assign w_en = rst & run;

    assign pc_inc     = w_en & w_cw[CW_PC_INC];
    assign pc_oe      = w_en & w_cw[CW_PC_OE];
    assign pc_load    = w_en & w_cw[CW_PC_LOAD];
    assign mar_load   = w_en & w_cw[CW_MAR_LOAD];
    assign mem_oe     = w_en & w_cw[CW_MEM_OE];
    assign mem_load   = w_en & w_cw[CW_MEM_LOAD];
    assign ir_load    = w_en & w_cw[CW_IR_LOAD];
    assign ir_oe      = w_en & w_cw[CW_IR_OE];
    assign a_load     = w_en & w_cw[CW_A_LOAD];
    assign a_oe       = w_en & w_cw[CW_A_OE];
    assign b_load     = w_en & w_cw[CW_B_LOAD];
    assign alu_oe     = w_en & w_cw[CW_ALU_OE];
    assign alu_sub    = w_en & w_cw[CW_ALU_SUB];
    assign flags_load = w_en & w_cw[CW_FLAGS_LOAD];
    assign out_load   = w_en & w_cw[CW_OUT_LOAD];

    assign halted = rst & (w_state == ST_HALT);
    assign step   = w_step;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_seq
// Desc     : Self-checking bench for cpu_ctrl_seq against a micro-op table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;
    logic pc_inc, pc_oe, pc_load, mar_load, mem_oe, mem_load, ir_load, ir_oe;
    logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halted;
    logic [2:0] step;

    int total = 0;
    int bad = 0;
    int oe_bad = 0;

    localparam int PC_INC = 0, PC_OE = 1, PC_LOAD = 2, MAR_LOAD = 3, MEM_OE = 4;
    localparam int MEM_LOAD = 5, IR_LOAD = 6, IR_OE = 7, A_LOAD = 8, A_OE = 9;
    localparam int B_LOAD = 10, ALU_OE = 11, ALU_SUB = 12, FLAGS_LOAD = 13, OUT_LOAD = 14;

    logic [14:0] obs;
    assign obs = {out_load, flags_load, alu_sub, alu_oe, b_load, a_oe, a_load, ir_oe,
                  ir_load, mem_load, mem_oe, mar_load, pc_load, pc_oe, pc_inc};

    cpu_ctrl_seq #(.OPCODE_W(4), .STEP_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .pc_inc(pc_inc), .pc_oe(pc_oe), .pc_load(pc_load), .mar_load(mar_load),
        .mem_oe(mem_oe), .mem_load(mem_load), .ir_load(ir_load), .ir_oe(ir_oe),
        .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe), .alu_sub(alu_sub),
        .flags_load(flags_load), .out_load(out_load), .halted(halted), .step(step)
    );

    always #5 clk = ~clk;

    // Model: instruction length and the micro-ops expected at step k.
    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctrl(input logic [3:0] op, input int k,
                                             input logic fc, input logic fz);
        logic [14:0] e = '0;
        if (k == 0) begin
            e[PC_OE] = 1'b1; e[MAR_LOAD] = 1'b1;
        end else if (k == 1) begin
            e[MEM_OE] = 1'b1; e[IR_LOAD] = 1'b1; e[PC_INC] = 1'b1;
        end else if (k == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: begin e[IR_OE] = 1'b1; e[MAR_LOAD] = 1'b1; end
                4'h5: begin e[IR_OE] = 1'b1; e[A_LOAD] = 1'b1; end
                4'h6: begin e[IR_OE] = 1'b1; e[PC_LOAD] = 1'b1; end
                4'h7: if (fc) begin e[IR_OE] = 1'b1; e[PC_LOAD] = 1'b1; end
                4'h8: if (fz) begin e[IR_OE] = 1'b1; e[PC_LOAD] = 1'b1; end
                4'hE: begin e[A_OE] = 1'b1; e[OUT_LOAD] = 1'b1; end
                default: ;
            endcase
        end else if (k == 3) begin
            case (op)
                4'h1: begin e[MEM_OE] = 1'b1; e[A_LOAD] = 1'b1; end
                4'h2, 4'h3: begin e[MEM_OE] = 1'b1; e[B_LOAD] = 1'b1; end
                4'h4: begin e[A_OE] = 1'b1; e[MEM_LOAD] = 1'b1; end
                default: ;
            endcase
        end else if (k == 4) begin
            e[ALU_OE] = 1'b1; e[A_LOAD] = 1'b1; e[FLAGS_LOAD] = 1'b1;
            e[ALU_SUB] = (op == 4'h3);
        end
        return e;
    endfunction

    // Bus-driver invariant, sampled mid-cycle on every clock.
    always @(negedge clk) begin
        #2;
        assert ($countones({pc_oe, mem_oe, ir_oe, a_oe, alu_oe}) <= 1)
        else begin
            oe_bad++;
            $display("FAIL oe_onehot t=%0t drivers=%b required at most one", $time,
                     {pc_oe, mem_oe, ir_oe, a_oe, alu_oe});
        end
    end

    // Leaves rst released at negedge+1 with the DUT in T0.
    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; run = 1'b1; opcode = 4'h1;
        @(negedge clk); #1;
        total++;
        if (obs !== 15'h0 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_outputs ctrl=%h halted=%b required ctrl=0 halted=0", obs, halted);
        end
        total++;
        if (step !== 3'd0) begin
            bad++; $display("FAIL reset_step step=%0d required 0", step);
        end
    endtask

    task automatic test_lda;
        opcode = 4'h1; run = 1'b1;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            total++;
            if (obs !== exp_ctrl(4'h1, k % 4, flag_c, flag_z) || step !== 3'(k % 4)) begin
                bad++;
                $display("FAIL lda_cycle%0d ctrl=%h step=%0d required ctrl=%h step=%0d", k, obs, step,
                         exp_ctrl(4'h1, k % 4, flag_c, flag_z), k % 4);
            end
        end
    endtask

    task automatic test_alu;
        logic [3:0] ops [2] = '{4'h3, 4'h2};
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i]; run = 1'b1;
            apply_reset();
            for (int k = 0; k < 6; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                total++;
                if (obs !== exp_ctrl(ops[i], k % 5, flag_c, flag_z) || step !== 3'(k % 5)) begin
                    bad++;
                    $display("FAIL alu_op%h_cycle%0d ctrl=%h step=%0d required ctrl=%h step=%0d", ops[i], k,
                             obs, step, exp_ctrl(ops[i], k % 5, flag_c, flag_z), k % 5);
                end
            end
        end
    endtask

    task automatic test_jumps;
        for (int j = 0; j < 4; j++) begin
            logic [3:0] op = (j < 2) ? 4'h7 : 4'h8;
            logic f = j[0];
            opcode = op; run = 1'b1;
            flag_c = (op == 4'h7) ? f : ~f;
            flag_z = (op == 4'h8) ? f : ~f;
            apply_reset();
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                total++;
                if (obs !== exp_ctrl(op, k % 3, flag_c, flag_z) || step !== 3'(k % 3)) begin
                    bad++;
                    $display("FAIL jump_op%h_f%0d_cycle%0d ctrl=%h step=%0d required ctrl=%h step=%0d", op, f, k,
                             obs, step, exp_ctrl(op, k % 3, flag_c, flag_z), k % 3);
                end
            end
        end
    endtask

    task automatic test_halt;
        opcode = 4'hF; run = 1'b1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            total++;
            if (obs !== exp_ctrl(4'hF, k, flag_c, flag_z) || halted !== 1'b0) begin
                bad++;
                $display("FAIL hlt_cycle%0d ctrl=%h halted=%b required ctrl=%h halted=0", k, obs, halted,
                         exp_ctrl(4'hF, k, flag_c, flag_z));
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            run = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (halted !== 1'b1 || obs !== 15'h0) begin
                bad++; $display("FAIL halt_hold%0d halted=%b ctrl=%h required halted=1 ctrl=0", c, halted, obs);
            end
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0 || step !== 3'd0) begin
            bad++; $display("FAIL halt_async_clear halted=%b step=%0d required halted=0 step=0", halted, step);
        end
        @(negedge clk);
        rst = 1'b1; run = 1'b1;
        #1;
        total++;
        if (step !== 3'd0 || obs !== exp_ctrl(4'hF, 0, flag_c, flag_z)) begin
            bad++; $display("FAIL halt_release step=%0d ctrl=%h required step=0 ctrl=%h", step, obs,
                            exp_ctrl(4'hF, 0, flag_c, flag_z));
        end
    endtask

    task automatic test_run_hold;
        int seq [6] = '{3, 3, 3, 3, 4, 0};
        opcode = 4'h2; run = 1'b1;
        apply_reset();
        @(negedge clk); @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            run = (c >= 3);
            #1;
            total++;
            if (obs !== (run ? exp_ctrl(4'h2, seq[c], flag_c, flag_z) : 15'h0) || step !== 3'(seq[c])) begin
                bad++;
                $display("FAIL run_hold_cycle%0d ctrl=%h step=%0d required ctrl=%h step=%0d", c, obs, step,
                         run ? exp_ctrl(4'h2, seq[c], flag_c, flag_z) : 15'h0, seq[c]);
            end
        end
    endtask

    task automatic test_async_reset;
        opcode = 4'h4; run = 1'b1;
        apply_reset();
        for (int k = 1; k < 4; k++) @(negedge clk);
        #1;
        total++;
        if (mem_load !== 1'b1 || a_oe !== 1'b1 || step !== 3'd3) begin
            bad++; $display("FAIL sta_t3 mem_load=%b a_oe=%b step=%0d required 1 1 3", mem_load, a_oe, step);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (mem_load !== 1'b0 || a_oe !== 1'b0 || obs !== 15'h0) begin
            bad++; $display("FAIL sta_async_drop ctrl=%h required 0", obs);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (step !== 3'd0 || obs !== exp_ctrl(4'h4, 0, flag_c, flag_z)) begin
            bad++; $display("FAIL sta_release step=%0d ctrl=%h required step=0 ctrl=%h", step, obs,
                            exp_ctrl(4'h4, 0, flag_c, flag_z));
        end
    endtask

    task automatic test_random;
        logic [3:0] op;
        logic [14:0] e;
        int k;
        run = 1'b0;
        apply_reset();
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 14));
            k = 0;
            while (k < exp_len(op)) begin
                @(negedge clk);
                if (k == 0) opcode = op;
                run = ($urandom_range(0, 3) != 0);
                flag_c = 1'($urandom_range(0, 1));
                flag_z = 1'($urandom_range(0, 1));
                #1;
                e = run ? exp_ctrl(op, k, flag_c, flag_z) : 15'h0;
                total++;
                if (obs !== e || step !== 3'(k) || halted !== 1'b0) begin
                    bad++;
                    $display("FAIL rand op=%h k=%0d run=%b ctrl=%h step=%0d halted=%b required ctrl=%h step=%0d halted=0",
                             op, k, run, obs, step, halted, e, k);
                end
                if (run) k++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_alu();
        test_jumps();
        test_halt();
        test_run_hold();
        test_async_reset();
        test_random();
        @(negedge clk); #3;
        total++;
        if (oe_bad !== 0) begin
            bad++; $display("FAIL oe_invariant_count violations=%0d required 0", oe_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Control sequencer for the 8-bit bus CPU. It steps a fetch/execute timing counter and decodes the current step together with the 4-bit opcode from the instruction register. From that it drives every load and output-enable strobe for the PC, MAR, memory, IR, A, B, ALU and output register. One bus driver per step; all register loads occur at the posedge that ends the step.

Parameters:
OPCODE_W, 4, opcode field width (upper nibble of IR).
STEP_W, 3, width of the step counter and the debug step output.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst  in  1  asynchronous, active-low reset.
run  in  1  1 = advance; 0 = freeze the current step.
opcode  in  OPCODE_W  IR upper nibble, stable from T2 onward.
flag_c  in  1  carry flag from the flags register.
flag_z  in  1  zero flag from the flags register.
pc_inc  out  1  increment PC.
pc_oe  out  1  PC drives bus.
pc_load  out  1  PC loads from bus.
mar_load  out  1  MAR loads from bus (low nibble).
mem_oe  out  1  memory drives bus at the MAR address.
mem_load  out  1  memory writes bus at the MAR address.
ir_load  out  1  IR loads from bus.
ir_oe  out  1  IR operand nibble drives bus.
a_load  out  1  A register loads.
a_oe  out  1  A drives bus.
b_load  out  1  B register loads.
alu_oe  out  1  ALU result drives bus.
alu_sub  out  1  ALU subtracts (A-B).
flags_load  out  1  flags register captures the ALU C and Z outputs.
out_load  out  1  output register loads.
halted  out  1  CPU stopped.
step  out  STEP_W  current step index, for debug.

Behaviour:
- States: T0..T4, plus HALT. Control outputs are a combinational decode of state, opcode and flags.
- Reset (rst=0, asynchronous): state goes to T0 and halted=0. All control outputs are forced 0 while rst=0. step=0.
- T0: pc_oe, mar_load.
- T1: mem_oe, ir_load, pc_inc.
- Opcodes 0x0 to 0x5:
  - 0x0 NOP: T2 none.
  - 0x1 LDA: T2 ir_oe+mar_load; T3 mem_oe+a_load.
  - 0x2 ADD: T2 ir_oe+mar_load; T3 mem_oe+b_load; T4 alu_oe+a_load+flags_load.
  - 0x3 SUB: same as ADD, plus alu_sub in T4 only.
  - 0x4 STA: T2 ir_oe+mar_load; T3 a_oe+mem_load.
  - 0x5 LDI: T2 ir_oe+a_load.
- Opcodes 0x6 to 0xF:
  - 0x6 JMP: T2 ir_oe+pc_load.
  - 0x7 JC: T2 ir_oe+pc_load if flag_c=1, otherwise none.
  - 0x8 JZ: T2 ir_oe+pc_load if flag_z=1, otherwise none.
  - 0xE OUT: T2 a_oe+out_load.
  - 0xF HLT: T2 none; the next edge enters HALT.
  - 0x9 to 0xD: decode as NOP.
- Variable length: the last step of each instruction returns to T0 on the next edge. No dead cycles. Lengths: NOP/LDI/JMP/JC/JZ/OUT = 3, LDA/STA = 4, ADD/SUB = 5.
- Flags are sampled combinationally in T2 only.
- HALT: halted=1 and all control outputs are 0. Only reset exits HALT; run is ignored.
- run=0: state is held and all control outputs are forced 0, so no loads occur. step keeps the held value. When run returns to 1, the held step's controls reassert and execution resumes. run has no effect on reset.
- Never more than one bus driver (the *_oe signals) is active in any state; this is an invariant.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - step encodings (T0..T4, HALT);
  - control-word bit indices;
  - the instruction-length table.
- One sub-module, step_counter: holds the state register, the async active-low reset, the run hold, the last-step return to T0, and HALT stickiness.
- The decode is a single combinational block in cpu_ctrl_seq.

Test Plan:
1. Reset, run=1, opcode=0x1 (LDA): the four cycles give T0 {pc_oe,mar_load}, T1 {mem_oe,ir_load,pc_inc}, T2 {ir_oe,mar_load}, T3 {mem_oe,a_load}. The fifth cycle is T0 again (step=0).
2. opcode=0x3 (SUB): step sequence 0,1,2,3,4,0. alu_sub=1 only in T4, together with alu_oe, a_load and flags_load. Repeat with opcode=0x2 and confirm alu_sub stays 0 throughout.
3. opcode=0x7 (JC):
   - flag_c=0: T2 has no controls and the instruction takes 3 cycles.
   - flag_c=1: T2 has ir_oe+pc_load.
   - Repeat both cases for JZ using flag_z.
4. opcode=0xF (HLT): halted=1 after the T2 edge and stays 1 with all outputs 0 for 20 cycles while run is toggled. Pulling rst low clears halted immediately; on release, step=0.
5. ADD with run=0 held for 3 cycles during T3: all outputs are 0 and step stays 3. When run=1, b_load asserts, then T4, then T0.
6. Drive rst low asynchronously mid-cycle during STA T3: mem_load and a_oe drop immediately, before the next edge. On release, the first cycle is T0.
7. Every scenario: an assertion checks that at most one *_oe is high per cycle.
